// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
package uart_pkg;

    // Receiver frame phases.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Encodings for the PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   push/push_data write request and data; ignored when full unless popping
//   pop            read request; ignored when empty
//   pop_data       current head (0 while empty)
//   full, empty    occupancy status
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);

    // Gate the head so the output is a defined 0 while nothing is stored.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - parametrised UART receiver with error checks and receive FIFO
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   rx            asynchronous serial input, idles high
//   rd_en         pop the FIFO head
//   rd_data       FIFO head (first-word fall-through), valid while rd_valid
//   rd_valid      FIFO not empty
//   fifo_full     FIFO holds FIFO_DEPTH entries
//   busy          receiver is inside a frame
//   frame_err     sticky: a stop bit sampled low
//   parity_err    sticky: parity mismatch
//   overrun       sticky: good byte arrived while FIFO full and not popping
//   err_clr       clears the sticky flags (a simultaneous set wins)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 fifo_full,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 err_clr
);

    // Timer counts down to 0; the sample happens in the cycle it reads 0.
    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [15:0]          timer_q, timer_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 tick;
    logic                 par_calc;
    logic                 par_bad;
    logic                 push;
    logic                 set_fe, set_pe, set_ov;
    logic                 fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            stop_bad_q <= stop_bad_d;
        end
    end

    assign tick     = (timer_q == '0);
    assign par_calc = (^shift_q) ^ par_bit_q;
    // Odd parity needs the XOR to be 1, even parity needs it to be 0.
    assign par_bad  = (PARITY == PAR_NONE) ? 1'b0 :
                      (PARITY == PAR_ODD)  ? !par_calc : par_calc;

    always_comb begin
        state_d    = state_q;
        timer_d    = tick ? timer_q : timer_q - 16'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        stop_bad_d = stop_bad_q;
        push       = 1'b0;
        set_fe     = 1'b0;
        set_pe     = 1'b0;
        set_ov     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    timer_d    = HALF_LOAD;
                    stop_bad_d = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        timer_d   = BIT_LOAD;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    timer_d = BIT_LOAD;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    par_bit_d = rx_s;
                    state_d   = STOP;
                    timer_d   = BIT_LOAD;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        // Final stop sample: decide the byte's fate, then rearm at once.
                        state_d = IDLE;
                        if (stop_bad_q || !rx_s) begin
                            set_fe = 1'b1;
                        end else if (par_bad) begin
                            set_pe = 1'b1;
                        end else if (fifo_full && !rd_en) begin
                            set_ov = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end else begin
                        stop_bad_d = stop_bad_q | !rx_s;
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        timer_d    = BIT_LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= set_fe | (frame_err  & !err_clr);
            parity_err <= set_pe | (parity_err & !err_clr);
            overrun    <= set_ov | (overrun    & !err_clr);
        end
    end

    assign busy     = (state_q != IDLE);
    assign rd_valid = !fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift_q),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo (8N1 and 7E2 instances)
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx0, rx1, rd_en0, rd_en1, err_clr0, err_clr1;
    logic [7:0] rd_data0;
    logic [6:0] rd_data1;
    logic       rd_valid0, rd_valid1, fifo_full0, fifo_full1, busy0, busy1;
    logic       frame_err0, frame_err1, parity_err0, parity_err1, overrun0, overrun1;

    uart_rx_fifo dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .rd_en(rd_en0), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .fifo_full(fifo_full0), .busy(busy0),
        .frame_err(frame_err0), .parity_err(parity_err0), .overrun(overrun0),
        .err_clr(err_clr0)
    );

    uart_rx_fifo #(
        .CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(2)
    ) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .rd_en(rd_en1), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .fifo_full(fifo_full1), .busy(busy1),
        .frame_err(frame_err1), .parity_err(parity_err1), .overrun(overrun1),
        .err_clr(err_clr1)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit         fe_m[2];
    bit         pe_m[2];
    bit         ov_m[2];

    function automatic int cpb(int s);    return s ? 8 : 16; endfunction
    function automatic int dbits(int s);  return s ? 7 : 8;  endfunction
    function automatic int par(int s);    return s ? 2 : 0;  endfunction
    function automatic int nstop(int s);  return s ? 2 : 1;  endfunction
    function automatic int depth(int s);  return s ? 2 : 4;  endfunction
    function automatic int final_edge(int s);
        return 3 + cpb(s) / 2 + (dbits(s) + (par(s) != 0 ? 1 : 0) + nstop(s)) * cpb(s);
    endfunction

    function automatic logic [31:0] o_valid(int s); return s ? 32'(rd_valid1)   : 32'(rd_valid0);   endfunction
    function automatic logic [31:0] o_full(int s);  return s ? 32'(fifo_full1)  : 32'(fifo_full0);  endfunction
    function automatic logic [31:0] o_busy(int s);  return s ? 32'(busy1)       : 32'(busy0);       endfunction
    function automatic logic [31:0] o_data(int s);  return s ? 32'(rd_data1)    : 32'(rd_data0);    endfunction
    function automatic logic [31:0] o_fe(int s);    return s ? 32'(frame_err1)  : 32'(frame_err0);  endfunction
    function automatic logic [31:0] o_pe(int s);    return s ? 32'(parity_err1) : 32'(parity_err0); endfunction
    function automatic logic [31:0] o_ov(int s);    return s ? 32'(overrun1)    : 32'(overrun0);    endfunction

    function automatic int qsize(int s); return s ? q1.size() : q0.size(); endfunction
    function automatic logic [8:0] qfront(int s); return s ? q1[0] : q0[0]; endfunction

    task automatic qpop(input int s);
        if (s) void'(q1.pop_front()); else void'(q0.pop_front());
    endtask
    task automatic qpush(input int s, input logic [8:0] v);
        if (s) q1.push_back(v); else q0.push_back(v);
    endtask
    task automatic set_rx(input int s, input logic v);
        if (s) rx1 = v; else rx0 = v;
    endtask
    task automatic set_rden(input int s, input logic v);
        if (s) rd_en1 = v; else rd_en0 = v;
    endtask
    task automatic set_clr(input int s, input logic v);
        if (s) err_clr1 = v; else err_clr0 = v;
    endtask
    task automatic clear_model(input int s);
        fe_m[s] = 0; pe_m[s] = 0; ov_m[s] = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_state(input int s, input string tag);
        chk($sformatf("%s.valid", tag), o_valid(s), 32'(qsize(s) != 0));
        chk($sformatf("%s.full", tag),  o_full(s),  32'(qsize(s) == depth(s)));
        if (qsize(s) != 0) chk($sformatf("%s.data", tag), o_data(s), 32'(qfront(s)));
        chk($sformatf("%s.frame_err", tag),  o_fe(s), 32'(fe_m[s]));
        chk($sformatf("%s.parity_err", tag), o_pe(s), 32'(pe_m[s]));
        chk($sformatf("%s.overrun", tag),    o_ov(s), 32'(ov_m[s]));
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one(input int s, input string tag);
        chk($sformatf("%s.pop_valid", tag), o_valid(s), 32'(1));
        if (qsize(s) != 0) chk($sformatf("%s.pop_data", tag), o_data(s), 32'(qfront(s)));
        set_rden(s, 1'b1);
        tick_n(1);
        set_rden(s, 1'b0);
        if (qsize(s) != 0) qpop(s);
    endtask

    task automatic pulse_clr(input int s);
        set_clr(s, 1'b1);
        tick_n(1);
        set_clr(s, 1'b0);
        clear_model(s);
    endtask

    // Drives one whole frame bit by bit; edge numbers count clock edges from the
    // first low rx level. pop_e/clr_e assert rd_en/err_clr in the cycle ending at that edge.
    task automatic send_frame(input int s, input logic [8:0] data, input bit par_flip,
                              input bit stop_low, input int pop_e, input int clr_e,
                              output int rise_e, output int brise_e, output int bfall_e);
        int         bp;
        int         total;
        logic       lv[$];
        logic       p;
        logic [8:0] d;
        logic [31:0] pv, pb;
        bp = cpb(s);
        d  = data & 9'((1 << dbits(s)) - 1);
        p  = 1'b0;
        lv.push_back(1'b0);
        for (int i = 0; i < dbits(s); i++) begin
            lv.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par(s) == 2) lv.push_back(p ^ par_flip);
        else if (par(s) == 1) lv.push_back(!p ^ par_flip);
        for (int i = 0; i < nstop(s); i++) lv.push_back(!stop_low);
        total   = lv.size() * bp;
        rise_e  = -1;
        brise_e = -1;
        bfall_e = -1;
        pv = o_valid(s);
        pb = o_busy(s);
        for (int c = 0; c < total; c++) begin
            set_rx(s, lv[c / bp]);
            set_rden(s, (c + 1) == pop_e);
            set_clr(s, (c + 1) == clr_e);
            if ((c + 1) == pop_e && qsize(s) != 0)
                chk("frame.pop_data", o_data(s), 32'(qfront(s)));
            @(posedge clk);
            #1;
            set_rden(s, 1'b0);
            set_clr(s, 1'b0);
            if ((c + 1) == pop_e && qsize(s) != 0) qpop(s);
            if (pv == 0 && o_valid(s) == 1 && rise_e < 0) rise_e = c + 1;
            if (pb == 0 && o_busy(s) == 1 && brise_e < 0) brise_e = c + 1;
            if (pb == 1 && o_busy(s) == 0 && bfall_e < 0) bfall_e = c + 1;
            pv = o_valid(s);
            pb = o_busy(s);
        end
        set_rx(s, 1'b1);
        if (clr_e > 0) clear_model(s);
        if (stop_low) fe_m[s] = 1;
        else if (par_flip && par(s) != 0) pe_m[s] = 1;
        else if (qsize(s) == depth(s)) ov_m[s] = 1;
        else qpush(s, d);
    endtask

    initial begin
        int         r, br, bf;
        logic [8:0] d;
        bit         saw_busy;

        rst = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1;
        rd_en0 = 1'b0; rd_en1 = 1'b0;
        err_clr0 = 1'b0; err_clr1 = 1'b0;
        clear_model(0);
        clear_model(1);
        tick_n(3);
        for (int s = 0; s < 2; s++) begin
            chk("reset.busy", o_busy(s), 32'(0));
            chk("reset.rd_data", o_data(s), 32'(0));
            check_state(s, "reset");
        end
        rst = 1'b0;
        tick_n(2);

        // 8N1: 0xAA with exact latency, then 0x2D after ten idle bit times.
        send_frame(0, 9'hAA, 0, 0, -1, -1, r, br, bf);
        chk("aa.rise_edge", 32'(r), 32'(final_edge(0)));
        chk("aa.busy_rise", 32'(br), 32'(3));
        chk("aa.busy_fall", 32'(bf), 32'(final_edge(0)));
        tick_n(160);
        send_frame(0, 9'h2D, 0, 0, -1, -1, r, br, bf);
        check_state(0, "aa2d");
        pop_one(0, "aa");
        pop_one(0, "2d");
        check_state(0, "aa2d.empty");

        // Random bytes with random idle gaps.
        for (int k = 0; k < 4; k++) begin
            d = 9'($urandom_range(0, 255));
            tick_n($urandom_range(0, 20));
            send_frame(0, d, 0, 0, -1, -1, r, br, bf);
            chk("rand0.rise_edge", 32'(r), 32'(final_edge(0)));
            pop_one(0, "rand0");
        end

        // 7E2: good parity, flipped parity, err_clr, set beating clear.
        send_frame(1, 9'h55, 0, 0, -1, -1, r, br, bf);
        chk("p55.rise_edge", 32'(r), 32'(final_edge(1)));
        pop_one(1, "p55");
        send_frame(1, 9'h55, 1, 0, -1, -1, r, br, bf);
        chk("p55bad.rise_edge", 32'(r), 32'(-1));
        check_state(1, "p55bad");
        pulse_clr(1);
        check_state(1, "p55clr");
        send_frame(1, 9'h55, 1, 0, -1, final_edge(1), r, br, bf);
        check_state(1, "set_wins");
        pulse_clr(1);
        for (int k = 0; k < 4; k++) begin
            d = 9'($urandom_range(0, 127));
            send_frame(1, d, 1'($urandom_range(0, 1)), 0, -1, -1, r, br, bf);
            check_state(1, "rand1");
            if (qsize(1) != 0) pop_one(1, "rand1");
            pulse_clr(1);
        end

        // Stop bit held low: byte dropped, frame_err set.
        send_frame(0, 9'h3C, 0, 1, -1, -1, r, br, bf);
        tick_n(40);
        chk("stop_low.busy", o_busy(0), 32'(0));
        check_state(0, "stop_low");
        pulse_clr(0);
        check_state(0, "stop_low.clr");

        // 3-cycle glitch: false start.
        saw_busy = 0;
        rx0 = 1'b0;
        tick_n(3);
        rx0 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick_n(1);
            if (busy0) saw_busy = 1;
        end
        chk("glitch.saw_busy", 32'(saw_busy), 32'(1));
        chk("glitch.busy", o_busy(0), 32'(0));
        check_state(0, "glitch");

        // Five back-to-back frames into a 4-deep FIFO.
        for (int k = 0; k < 5; k++) begin
            send_frame(0, 9'($urandom_range(0, 255)), 0, 0, -1, -1, r, br, bf);
        end
        check_state(0, "ovr");
        for (int k = 0; k < 4; k++) pop_one(0, "ovr");
        check_state(0, "ovr.empty");
        pulse_clr(0);

        // Same, but popping in the fifth frame's final-sample cycle.
        for (int k = 0; k < 5; k++) begin
            send_frame(0, 9'($urandom_range(0, 255)), 0, 0,
                       (k == 4) ? final_edge(0) : -1, -1, r, br, bf);
        end
        check_state(0, "pushpop");
        for (int k = 0; k < 4; k++) pop_one(0, "pushpop");
        check_state(0, "pushpop.empty");

        // Reset in the middle of the data bits.
        send_frame(0, 9'h5A, 0, 0, -1, -1, r, br, bf);
        rx0 = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c >= 16) rx0 = 1'($urandom_range(0, 1));
            tick_n(1);
        end
        chk("midrst.busy_before", o_busy(0), 32'(1));
        rst = 1'b1;
        rx0 = 1'b1;
        tick_n(1);
        q0.delete();
        q1.delete();
        clear_model(0);
        clear_model(1);
        chk("midrst.busy", o_busy(0), 32'(0));
        check_state(0, "midrst");
        rst = 1'b0;
        tick_n(200);
        send_frame(0, 9'h81, 0, 0, -1, -1, r, br, bf);
        chk("x81.rise_edge", 32'(r), 32'(final_edge(0)));
        pop_one(0, "x81");
        check_state(0, "x81.empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
